// File: rtl/lm32_dp_ram_be.sv
// rtl/lm32_dp_ram_be.sv - simple dual-port RAM with byte-lane write enables
// One write port and one read port; optional output register and selectable read-during-write policy.
module lm32_dp_ram_be #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int OUT_REG    = 0,
   parameter int RDW_MODE   = 0
) (
   input  logic                               clk_i,
   input  logic                               rst_n_i,
   input  logic                               we_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_i,
   input  logic [ADDR_WIDTH-1:0]              waddr_i,
   input  logic [DATA_WIDTH-1:0]              wdata_i,
   input  logic                               re_i,
   input  logic [ADDR_WIDTH-1:0]              raddr_i,
   output logic [DATA_WIDTH-1:0]              rdata_o,
   output logic                               rvalid_o
);
   localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_lane_width
      $error("lm32_dp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   // Contents start at zero for simulation and FPGA configuration; reset never touches them.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

   logic [LANES-1:0]      w_wr_lanes;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic                  r_s1_valid;

   assign w_wr_lanes = (we_i && rst_n_i) ? be_i : '0;

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < LANES; k++) begin
         if (w_wr_lanes[k]) begin
            r_mem[waddr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Write-through mode forwards only the lanes being written on a same-address collision.
   always_comb begin
      w_rd_word = r_mem[raddr_i];
      if ((RDW_MODE != 0) && (waddr_i == raddr_i)) begin
         for (int k = 0; k < LANES; k++) begin
            if (w_wr_lanes[k]) begin
               w_rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_s1_data  <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= re_i;
         if (re_i) begin
            r_s1_data <= w_rd_word;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_out_data;
      logic                  r_out_valid;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_data <= r_s1_data;
            end
         end
      end

      assign rdata_o  = r_out_data;
      assign rvalid_o = r_out_valid;
   end else begin : g_no_out_reg
      assign rdata_o  = r_s1_data;
      assign rvalid_o = r_s1_valid;
   end

endmodule

// File: tb/tb_lm32_dp_ram_be.sv
// tb/tb_lm32_dp_ram_be.sv - self-checking bench for lm32_dp_ram_be
// Three instances share stimulus: latency-1 old-data, latency-1 write-through, latency-2 old-data.
module tb_lm32_dp_ram_be;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [9:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        re = 1'b0;
   logic [9:0]  raddr = '0;

   logic [31:0] d0, d1, d2;
   logic        v0, v1, v2;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference: word array plus expected visible outputs of each instance.
   logic [31:0] mdl [1024];
   logic        e0_v = 1'b0, e1_v = 1'b0, e2_v = 1'b0;
   logic [31:0] e0_d = '0, e1_d = '0, e2_d = '0;
   typedef struct {
      int          due;
      logic [31:0] d;
   } rd_t;
   rd_t pend[$];

   always #5 clk = ~clk;

   lm32_dp_ram_be #(.OUT_REG(0), .RDW_MODE(0)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
      .re_i(re), .raddr_i(raddr), .rdata_o(d0), .rvalid_o(v0));
   lm32_dp_ram_be #(.OUT_REG(0), .RDW_MODE(1)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
      .re_i(re), .raddr_i(raddr), .rdata_o(d1), .rvalid_o(v1));
   lm32_dp_ram_be #(.OUT_REG(1), .RDW_MODE(0)) u_dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
      .re_i(re), .raddr_i(raddr), .rdata_o(d2), .rvalid_o(v2));

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] lanes);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (lanes[k]) r[k*8 +: 8] = nw[k*8 +: 8];
      return r;
   endfunction

   // One rising edge; the model consumes whatever inputs were applied, then we sit 1ns past the edge.
   task automatic tick();
      logic [31:0] old_w, new_w;
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         old_w = mdl[raddr];
         new_w = (we && waddr == raddr) ? merge(old_w, wdata, be) : old_w;
         if (we) mdl[waddr] = merge(mdl[waddr], wdata, be);
         e0_v = re;
         e1_v = re;
         if (re) begin
            e0_d = old_w;
            e1_d = new_w;
         end
         e2_v = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e2_v = 1'b1;
            e2_d = pend[0].d;
            void'(pend.pop_front());
         end
         if (re) pend.push_back('{cyc + 1, old_w});
      end
      #1;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      e0_v = 1'b0; e1_v = 1'b0; e2_v = 1'b0;
      e0_d = '0;   e1_d = '0;   e2_d = '0;
      pend.delete();
   endtask

   task automatic test_reset();
      assert_reset();
      #1;
      n_cmp++;
      if ({v0, d0, v1, d1, v2, d2} !== 99'd0) begin
         n_fail++;
         $display("FAIL reset_async: got %h required 0", {v0, d0, v1, d1, v2, d2});
      end
      tick();
      n_cmp++;
      if ({v0, d0, v1, d1, v2, d2} !== 99'd0) begin
         n_fail++;
         $display("FAIL reset_held: got %h required 0", {v0, d0, v1, d1, v2, d2});
      end
      rst_n = 1'b1;
      re = 1'b1; raddr = 10'h123;
      tick();
      re = 1'b0;
      n_cmp++;
      if ({v0, d0, v1, d1, v2} !== {1'b1, 32'h0, 1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL first_read_after_reset: got v0=%b d0=%h v1=%b d1=%h v2=%b required 1/0/1/0/0",
                  v0, d0, v1, d1, v2);
      end
      tick();
      n_cmp++;
      if ({v0, v2, d2} !== {1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL zero_init_outreg: got v0=%b v2=%b d2=%h required 0/1/00000000", v0, v2, d2);
      end
   endtask

   task automatic test_full_write();
      we = 1'b1; be = 4'hF; waddr = 10'h005; wdata = 32'hDEADBEEF;
      tick();
      we = 1'b0; re = 1'b1; raddr = 10'h005;
      tick();
      re = 1'b0;
      n_cmp++;
      if ({v0, d0, v1, d1, v2} !== {1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0}) begin
         n_fail++;
         $display("FAIL full_write_lat1: got v0=%b d0=%h v1=%b d1=%h v2=%b required 1/deadbeef/1/deadbeef/0",
                  v0, d0, v1, d1, v2);
      end
      tick();
      n_cmp++;
      if ({v0, d0, v2, d2} !== {1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL full_write_lat2: got v0=%b d0=%h v2=%b d2=%h required 0/deadbeef/1/deadbeef",
                  v0, d0, v2, d2);
      end
   endtask

   task automatic test_byte_enable();
      we = 1'b1; be = 4'b0101; waddr = 10'h005; wdata = 32'h11223344;
      tick();
      we = 1'b0; re = 1'b1; raddr = 10'h005;
      tick();
      re = 1'b0;
      n_cmp++;
      if ({v0, d0, v1, d1} !== {1'b1, 32'hDE22BE44, 1'b1, 32'hDE22BE44}) begin
         n_fail++;
         $display("FAIL byte_enable: got d0=%h d1=%h required de22be44", d0, d1);
      end
      tick();
      n_cmp++;
      if ({v2, d2} !== {1'b1, 32'hDE22BE44}) begin
         n_fail++;
         $display("FAIL byte_enable_outreg: got v2=%b d2=%h required 1/de22be44", v2, d2);
      end
   endtask

   task automatic test_be_zero_hold();
      we = 1'b1; be = 4'h0; waddr = 10'h005; wdata = 32'hFFFFFFFF;
      tick();
      we = 1'b0; re = 1'b1; raddr = 10'h005;
      tick();
      re = 1'b0;
      n_cmp++;
      if ({v0, d0} !== {1'b1, 32'hDE22BE44}) begin
         n_fail++;
         $display("FAIL be_zero_write: got v0=%b d0=%h required 1/de22be44", v0, d0);
      end
      // be and wdata toggle with we low; none of it may reach memory.
      for (int i = 0; i < 5; i++) begin
         be = 4'hF; wdata = 32'h0BAD0BAD; waddr = 10'h005;
         tick();
         n_cmp++;
         if ({v0, d0, v1, d1, v2, d2} !== {1'b0, 32'hDE22BE44, 1'b0, 32'hDE22BE44, (i == 0), 32'hDE22BE44}) begin
            n_fail++;
            $display("FAIL idle_hold[%0d]: got v0=%b d0=%h v1=%b d1=%h v2=%b d2=%h", i, v0, d0, v1, d1, v2, d2);
         end
      end
   endtask

   task automatic test_rdw();
      we = 1'b1; be = 4'hF; waddr = 10'h010; wdata = 32'hAAAAAAAA;
      tick();
      be = 4'b0011; wdata = 32'h55555555; re = 1'b1; raddr = 10'h010;
      tick();
      we = 1'b0; re = 1'b0;
      n_cmp++;
      if ({v0, d0, v1, d1} !== {1'b1, 32'hAAAAAAAA, 1'b1, 32'hAAAA5555}) begin
         n_fail++;
         $display("FAIL rdw_same_edge: got d0=%h d1=%h required aaaaaaaa/aaaa5555", d0, d1);
      end
      tick();
      n_cmp++;
      if ({v2, d2} !== {1'b1, 32'hAAAAAAAA}) begin
         n_fail++;
         $display("FAIL rdw_outreg: got v2=%b d2=%h required 1/aaaaaaaa", v2, d2);
      end
      we = 1'b1; be = 4'hF; waddr = 10'h020; wdata = 32'h12345678; re = 1'b1; raddr = 10'h010;
      tick();
      we = 1'b0; raddr = 10'h020;
      n_cmp++;
      if ({d0, d1} !== {32'hAAAA5555, 32'hAAAA5555}) begin
         n_fail++;
         $display("FAIL rdw_diff_addr: got d0=%h d1=%h required aaaa5555", d0, d1);
      end
      tick();
      re = 1'b0;
      n_cmp++;
      if ({d0, d1} !== {32'h12345678, 32'h12345678}) begin
         n_fail++;
         $display("FAIL diff_addr_write: got d0=%h d1=%h required 12345678", d0, d1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [9:0]  addrs [3];
      logic [31:0] vals  [3];
      addrs[0] = 10'h000; addrs[1] = 10'h3FF; addrs[2] = 10'h001;
      vals[0] = 32'h01234567; vals[1] = 32'h89ABCDEF; vals[2] = 32'h0BADF00D;
      be = 4'hF;
      for (int i = 0; i < 3; i++) begin
         we = 1'b1; waddr = addrs[i]; wdata = vals[i];
         tick();
      end
      we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         re = (i < 3);
         if (i < 3) raddr = addrs[i];
         tick();
         n_cmp++;
         if (v2 !== (i >= 1 && i <= 3) || (i >= 1 && i <= 3 && d2 !== vals[i-1])
             || v0 !== (i < 3) || (i < 3 && d0 !== vals[i])) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got v0=%b d0=%h v2=%b d2=%h", i, v0, d0, v2, d2);
         end
      end
      re = 1'b0;
   endtask

   task automatic test_reset_inflight();
      re = 1'b1; raddr = 10'h005;
      tick();
      re = 1'b0;
      #2;
      assert_reset();
      #1;
      n_cmp++;
      if ({v0, d0, v1, d1, v2, d2} !== 99'd0) begin
         n_fail++;
         $display("FAIL reset_midflight: got %h required 0", {v0, d0, v1, d1, v2, d2});
      end
      we = 1'b1; be = 4'hF; waddr = 10'h005; wdata = 32'hBAD0BAD0;
      tick();
      we = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({v0, v1, v2, d2} !== 35'd0) begin
            n_fail++;
            $display("FAIL no_strobe_after_reset[%0d]: got v0=%b v1=%b v2=%b d2=%h required 0", i, v0, v1, v2, d2);
         end
      end
      re = 1'b1; raddr = 10'h005;
      tick();
      re = 1'b0;
      n_cmp++;
      if ({v0, d0, v1, d1} !== {1'b1, 32'hDE22BE44, 1'b1, 32'hDE22BE44}) begin
         n_fail++;
         $display("FAIL preserved_after_reset: got d0=%h d1=%h required de22be44", d0, d1);
      end
      tick();
      n_cmp++;
      if ({v2, d2} !== {1'b1, 32'hDE22BE44}) begin
         n_fail++;
         $display("FAIL preserved_outreg: got v2=%b d2=%h required 1/de22be44", v2, d2);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         we = 1'($urandom);
         be = 4'($urandom);
         wdata = $urandom;
         waddr = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
         re = 1'($urandom);
         raddr = ($urandom_range(0, 3) == 0) ? waddr : 10'($urandom_range(0, 15));
         tick();
         n_cmp++;
         if ({v0, d0, v1, d1, v2, d2} !== {e0_v, e0_d, e1_v, e1_d, e2_v, e2_d}) begin
            n_fail++;
            $display("FAIL random[%0d]: got %b/%h %b/%h %b/%h required %b/%h %b/%h %b/%h", i,
                     v0, d0, v1, d1, v2, d2, e0_v, e0_d, e1_v, e1_d, e2_v, e2_d);
         end
      end
      we = 1'b0; re = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mdl[i] = '0;
      test_reset();
      test_full_write();
      test_byte_enable();
      test_be_zero_hold();
      test_rdw();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lm32_dp_ram_be.md
LM32_DP_RAM_BE -- requirements
Module: lm32_dp_ram_be

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, address bits; depth is exactly 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 8, write-enable lane width; DATA_WIDTH SHALL be an integer multiple of BYTE_WIDTH, and elaboration SHALL fail otherwise.
REQ-004 The block SHALL have parameter OUT_REG, default 0, where 1 adds an output pipeline register.
REQ-005 The block SHALL have parameter RDW_MODE, default 0, read-during-write policy: 0 = old data, 1 = write-through.
REQ-006 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-007 The block SHALL have port rst_n_i, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port we_i, input, 1 bit, write request.
REQ-009 The block SHALL have port be_i, input, DATA_WIDTH/BYTE_WIDTH bits, per-lane write enable, where bit k covers wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH].
REQ-010 The block SHALL have port waddr_i, input, ADDR_WIDTH bits, write address.
REQ-011 The block SHALL have port wdata_i, input, DATA_WIDTH bits, write data.
REQ-012 The block SHALL have port re_i, input, 1 bit, read request.
REQ-013 The block SHALL have port raddr_i, input, ADDR_WIDTH bits, read address.
REQ-014 The block SHALL have port rdata_o, output, DATA_WIDTH bits, read data.
REQ-015 The block SHALL have port rvalid_o, output, 1 bit, a one-cycle strobe marking rdata_o updated with a new read result.

Function
REQ-016 A write SHALL occur on an edge with we_i=1: each lane k with be_i[k]=1 is updated at waddr_i, and lanes with be_i[k]=0 keep their contents.
REQ-017 we_i=1 with be_i all zero SHALL leave memory unchanged; be_i SHALL be ignored when we_i=0.
REQ-018 A read SHALL be sampled on an edge with re_i=1; with OUT_REG=0, rdata_o and rvalid_o=1 SHALL appear after that edge (latency 1).
REQ-019 With OUT_REG=1, read data and strobe SHALL pass through one more register stage (latency 2); back-to-back reads SHALL be accepted every cycle at full throughput in both modes.
REQ-020 When no new read result arrives, rdata_o SHALL hold its last value and rvalid_o SHALL be 0.
REQ-021 A read and a write to the same address on the same edge with RDW_MODE=0 SHALL return the pre-write word.
REQ-022 A read and a write to the same address on the same edge with RDW_MODE=1 SHALL return new data in lanes with be_i[k]=1 and old data elsewhere.
REQ-023 A read and a write to different addresses on the same edge SHALL be independent, and both SHALL complete.
REQ-024 Addresses SHALL cover the full range 0..2**ADDR_WIDTH-1 with no aliasing, and no wrap logic SHALL be required.
REQ-025 Memory SHALL be initialised to all zero at time zero for simulation and FPGA configuration.

Reset
REQ-026 rst_n_i=0 SHALL asynchronously force rdata_o=0, rvalid_o=0 and all internal read pipeline registers to 0/invalid.
REQ-027 Reset SHALL NOT clear memory contents; writes SHALL be suppressed while rst_n_i=0.
REQ-028 A read in flight when reset asserts SHALL be discarded, and no rvalid_o pulse SHALL follow deassertion for it.
REQ-029 The first read request SHALL be accepted on the first rising edge after rst_n_i deasserts.

Verification
REQ-030 The bench SHALL cover: defaults, write 0xDEADBEEF @0x005 with be=1111, then read @0x005 -> rvalid_o=1 and rdata_o=0xDEADBEEF one cycle after the read edge.
REQ-031 The bench SHALL cover: over 0xDEADBEEF, write 0x11223344 @0x005 with be=0101, then read -> 0xDE22BE44.
REQ-032 The bench SHALL cover: RDW_MODE=0 vs 1, word 0xAAAAAAAA @0x010, then a same-edge write of 0x55555555 with be=0011 and a read @0x010 -> 0xAAAAAAAA (mode 0) / 0xAAAA5555 (mode 1).
REQ-033 The bench SHALL cover: OUT_REG=1, reads of 0x000, 0x3FF, 0x001 on consecutive edges -> three consecutive rvalid_o pulses, each two cycles after its request, with data in order; 0x3FF SHALL not alias 0x000.
REQ-034 The bench SHALL cover: a read issued, then rst_n_i pulsed low mid-latency -> rdata_o=0 and rvalid_o=0 immediately, with no later strobe; a subsequent read of the earlier-written address SHALL return the preserved data.
REQ-035 The bench SHALL cover: we_i=1 with be=0000 @0x005, then read -> unchanged contents; re_i=0 for 5 cycles -> rdata_o stable and rvalid_o=0.
